// File: rtl/fifo_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bus_arbiter
// Purpose  : Round-robin arbiter that shares one addressed-FIFO bus between
//            several burst requesters, with full/empty throttling and watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_bus_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADRESS_WIDTH = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_push,
    input  logic [NUM_REQ*ADRESS_WIDTH-1:0] req_adress,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              beat_ack,
    output logic [NUM_REQ-1:0]              req_error,
    output logic                            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            busy,
    output logic [ADRESS_WIDTH-1:0]         bus_adress,
    output logic [DATA_WIDTH-1:0]           bus_data_in,
    output logic                            bus_read_enable,
    output logic                            bus_write_enable,
    input  logic [DATA_WIDTH-1:0]           bus_data_out,
    input  logic [2**ADRESS_WIDTH-1:0]      fifo_full,
    input  logic [2**ADRESS_WIDTH-1:0]      fifo_empty
);

    localparam int c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDX_W-1:0]      r_ptr;
    logic [c_IDX_W-1:0]      r_gnt;
    logic [c_IDX_W-1:0]      w_pick;
    logic                    w_pick_valid;
    logic [ADRESS_WIDTH-1:0] r_adr;
    logic                    r_push;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [c_STALL_W-1:0]    r_stall;
    logic                    w_ready;
    logic                    w_beat;
    logic                    w_abort;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_data;

    // Scan from farthest to nearest so the requester closest after r_ptr wins.
    always_comb begin
        int idx;
        idx          = 0;
        w_pick       = r_ptr;
        w_pick_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req[c_IDX_W'(idx)]) begin
                w_pick       = c_IDX_W'(idx);
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_ready = r_push ? !fifo_full[r_adr] : !fifo_empty[r_adr];
    assign w_beat  = (r_state == ST_XFER) && w_ready;
    assign w_abort = (r_state == ST_XFER) && !w_ready &&
                     (r_stall == c_STALL_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt      = r_state;
        grant            = '0;
        beat_ack         = '0;
        req_error        = '0;
        busy             = 1'b0;
        bus_adress       = '0;
        bus_data_in      = '0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                busy         = 1'b1;
                grant[r_gnt] = 1'b1;
                bus_adress   = r_adr;
                if (r_push) begin
                    bus_data_in = req_data[int'(r_gnt)*DATA_WIDTH +: DATA_WIDTH];
                end
                if (w_ready) begin
                    bus_read_enable  = r_push;
                    bus_write_enable = !r_push;
                    beat_ack[r_gnt]  = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_abort) begin
                    req_error[r_gnt] = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= c_IDX_W'(NUM_REQ - 1);
            r_gnt        <= '0;
            r_adr        <= '0;
            r_push       <= 1'b0;
            r_cnt        <= '0;
            r_stall      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_beat && !r_push;
            if (w_beat && !r_push) begin
                r_resp_data <= bus_data_out;
            end
            if (r_state == ST_IDLE) begin
                r_stall <= '0;
                if (w_pick_valid) begin
                    r_gnt  <= w_pick;
                    r_adr  <= req_adress[int'(w_pick)*ADRESS_WIDTH +: ADRESS_WIDTH];
                    r_push <= req_push[w_pick];
                    r_cnt  <= req_len[int'(w_pick)*LEN_WIDTH +: LEN_WIDTH];
                end
            end else if (w_beat) begin
                r_stall <= '0;
                // r_cnt holds remaining beats minus one, so it never wraps.
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_ptr <= r_gnt;
                end
            end else begin
                r_stall <= r_stall + 1'b1;
                if (w_abort) begin
                    r_ptr <= r_gnt;
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_bus_arbiter
// Purpose  : Self-checking bench with FIFO-bank and requester models plus a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_bus_arbiter;

    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int TO = 16;
    localparam int NF = 2 ** AW;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_push;
    logic [NR*AW-1:0]  req_adress;
    logic [NR*LW-1:0]  req_len;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     beat_ack;
    logic [NR-1:0]     req_error;
    logic              resp_valid;
    logic [DW-1:0]     resp_data;
    logic              busy;
    logic [AW-1:0]     bus_adress;
    logic [DW-1:0]     bus_data_in;
    logic              bus_read_enable;
    logic              bus_write_enable;
    logic [DW-1:0]     bus_data_out;
    logic [NF-1:0]     fifo_full;
    logic [NF-1:0]     fifo_empty;

    fifo_bus_arbiter #(
        .NUM_REQ(NR), .ADRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .LEN_WIDTH(LW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_push(req_push),
        .req_adress(req_adress), .req_len(req_len), .req_data(req_data),
        .grant(grant), .beat_ack(beat_ack), .req_error(req_error),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
        .bus_adress(bus_adress), .bus_data_in(bus_data_in),
        .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
        .bus_data_out(bus_data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clock = ~clock;

    // FIFO bank: address 15 is 16 deep so a maximum-length burst fits.
    function automatic int fdepth(input int a);
        return (a == NF - 1) ? 16 : 4;
    endfunction

    logic [DW-1:0] fmem [NF][16];
    int            fcnt [NF] = '{default: 0};
    logic [NF-1:0] empty_force = '0;

    always @(posedge clock) begin
        if (bus_read_enable && fcnt[bus_adress] < fdepth(int'(bus_adress))) begin
            fmem[bus_adress][fcnt[bus_adress]] <= bus_data_in;
            fcnt[bus_adress] <= fcnt[bus_adress] + 1;
        end else if (bus_write_enable && fcnt[bus_adress] > 0) begin
            for (int i = 0; i < 15; i++) fmem[bus_adress][i] <= fmem[bus_adress][i+1];
            fcnt[bus_adress] <= fcnt[bus_adress] - 1;
        end
    end

    always_comb begin
        for (int a = 0; a < NF; a++) begin
            fifo_full[a]  = fcnt[a] >= fdepth(a);
            fifo_empty[a] = (fcnt[a] == 0) || empty_force[a];
        end
    end

    assign bus_data_out = (fcnt[bus_adress] > 0) ? fmem[bus_adress][0] : '0;

    // Requesters: data source advances on beat_ack.
    logic [DW-1:0] src [NR][16];
    int            bptr [NR] = '{default: 0};
    logic          clr_bptr = 1'b0;

    always @(posedge clock) begin
        for (int i = 0; i < NR; i++) begin
            if (clr_bptr) bptr[i] <= 0;
            else if (beat_ack[i] && bptr[i] < 15) bptr[i] <= bptr[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = src[i][bptr[i]];
    end

    // Reference model state.
    int            n_total = 0;
    int            n_bad   = 0;
    int            ref_ptr = NR - 1;
    int            last_w  = -1;
    logic [DW-1:0] sbm [NF][16];
    int            sbc [NF] = '{default: 0};
    bit            exp_rv = 1'b0;
    logic [DW-1:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp();
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) chk("resp_data", 32'(resp_data), 32'(exp_rd));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, {grant, beat_ack, req_error, busy, resp_valid,
                            bus_read_enable, bus_write_enable}, 32'h0);
        chk({tag, "_bus"}, {resp_data, bus_adress, bus_data_in}, 32'h0);
    endtask

    task automatic set_req(input int i, input bit push, input int adr, input int len);
        req_push[i]          = push;
        req_adress[i*AW +: AW] = AW'(adr);
        req_len[i*LW +: LW]    = LW'(len);
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_burst(input int rst_at, input bit toggle);
        int w, adr, len, beats, stall, cyc;
        bit push, ready, done, nrv;
        logic [DW-1:0] nrd;
        w = -1;
        for (int k = NR; k >= 1; k--) if (req[(ref_ptr + k) % NR]) w = (ref_ptr + k) % NR;
        if (w < 0) return;
        last_w = w;
        adr  = int'(req_adress[w*AW +: AW]);
        len  = int'(req_len[w*LW +: LW]);
        push = req_push[w];
        clr_bptr = 1'b1;
        @(negedge clock);
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_busy_en", {busy, bus_read_enable, bus_write_enable}, 32'h0);
        chk("idle_din", 32'(bus_data_in), 32'h0);
        chk_resp();
        exp_rv = 1'b0;
        @(posedge clock); #1;
        clr_bptr = 1'b0;
        beats = 0; stall = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            if (toggle) empty_force[adr] = (cyc % 2 == 0);
            if (cyc == rst_at) begin
                reset = 1'b1;
                #1;
                chk_all_zero("rst_mid");
                @(posedge clock); #1;
                reset = 1'b0;
                ref_ptr = NR - 1;
                exp_rv  = 1'b0;
                return;
            end
            ready = push ? (sbc[adr] < fdepth(adr)) : (sbc[adr] > 0 && !empty_force[adr]);
            @(negedge clock);
            chk("grant", 32'(grant), 32'(1) << w);
            chk("busy", 32'(busy), 32'h1);
            chk("bus_adr", 32'(bus_adress), 32'(adr));
            chk("rd_en", 32'(bus_read_enable), 32'(ready && push));
            chk("wr_en", 32'(bus_write_enable), 32'(ready && !push));
            chk("beat_ack", 32'(beat_ack), ready ? (32'(1) << w) : 32'h0);
            chk_resp();
            nrv = 1'b0; nrd = '0;
            if (ready) begin
                chk("req_error", 32'(req_error), 32'h0);
                if (push) begin
                    chk("bus_din", 32'(bus_data_in), 32'(src[w][beats]));
                    sbm[adr][sbc[adr]] = src[w][beats];
                    sbc[adr]++;
                end else begin
                    nrv = 1'b1;
                    nrd = sbm[adr][0];
                    for (int i = 0; i < 15; i++) sbm[adr][i] = sbm[adr][i+1];
                    sbc[adr]--;
                end
                beats++;
                stall = 0;
                if (beats == len + 1) done = 1'b1;
            end else begin
                stall++;
                chk("req_error", 32'(req_error), (stall == TO) ? (32'(1) << w) : 32'h0);
                if (stall == TO) done = 1'b1;
            end
            exp_rv = nrv;
            if (nrv) exp_rd = nrd;
            @(posedge clock); #1;
            cyc++;
        end
        if (!done) chk("burst_bound", 32'(cyc), 32'(len + 1 + TO));
        ref_ptr = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; req = '0; req_push = '0; req_adress = '0; req_len = '0;
        for (int i = 0; i < NR; i++) for (int k = 0; k < 16; k++) src[i][k] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Push 1..4 to FIFO 7 from requester 0.
        for (int k = 0; k < 4; k++) src[0][k] = DW'(k + 1);
        set_req(0, 1'b1, 7, 3); req = 4'b0001;
        run_burst(-1, 1'b0);
        req = '0;
        chk("full7", 32'(fifo_full[7]), 32'h1);

        // Pop the same four back through requester 1.
        set_req(1, 1'b0, 7, 3); req = 4'b0010;
        run_burst(-1, 1'b0);
        req = '0;

        // Fairness: all held, single-beat pushes, from a fresh pointer.
        reset = 1'b1; #1; reset = 1'b0; ref_ptr = NR - 1; exp_rv = 1'b0;
        for (int i = 0; i < NR; i++) begin
            src[i][0] = DW'($urandom);
            set_req(i, 1'b1, i, 0);
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_burst(-1, 1'b0);
            chk("rr_order", 32'(last_w), 32'(n % NR));
        end
        req = '0;

        // Overlong push into a depth-4 FIFO triggers the watchdog.
        for (int k = 0; k < 6; k++) src[2][k] = DW'(8'hA0 + k);
        set_req(2, 1'b1, 9, 5); req = 4'b0100;
        run_burst(-1, 1'b0);

        // Pointer now at 2, so requester 3 wins over 0.
        src[3][0] = 8'h5A; src[3][1] = 8'hC3;
        set_req(3, 1'b1, 5, 1); set_req(0, 1'b1, 6, 0); req = 4'b1101;
        run_burst(-1, 1'b0);
        chk("ptr_after_abort", 32'(last_w), 32'h3);

        // Pop with an empty flag that toggles every cycle.
        set_req(0, 1'b0, 5, 1); req = 4'b0001;
        run_burst(-1, 1'b1);
        req = '0; empty_force = '0;

        // Maximum-length burst in and out of the deep FIFO.
        for (int k = 0; k < 16; k++) src[1][k] = DW'($urandom);
        set_req(1, 1'b1, NF - 1, 15); req = 4'b0010;
        run_burst(-1, 1'b0);
        set_req(2, 1'b0, NF - 1, 15); req = 4'b0100;
        run_burst(-1, 1'b0);
        req = '0;

        // Reset during the second beat of a four-beat push.
        for (int k = 0; k < 4; k++) src[0][k] = DW'(8'h30 + k);
        set_req(0, 1'b1, 11, 3); req = 4'b0001;
        run_burst(1, 1'b0);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 12, 0);
        req = 4'b1111;
        run_burst(-1, 1'b0);
        chk("prio_after_reset", 32'(last_w), 32'h0);
        req = '0;

        // Randomized traffic over a small set of addresses.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NR; i++) begin
                for (int k = 0; k < 16; k++) src[i][k] = DW'($urandom);
                set_req(i, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
            end
            req = NR'($urandom_range(1, 15));
            run_burst(-1, 1'b0);
        end
        req = '0;
        @(negedge clock);
        chk_resp();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_bus_arbiter.md
Name: fifo_bus_arbiter

Overview:
- Round-robin arbiter that shares one addressed-FIFO bus (active_adress, data_in, read_enable, write_enable, data_out) between num_req requesters.
- Each requester asks for a burst of push or pop beats to one FIFO address. The arbiter grants one requester at a time and drives the bus.
- It throttles beats on the target FIFO's full/empty flags and aborts stuck bursts with a watchdog.
- It sits between the UART-side clients and the bank of addressed FIFOs.

Parameters:
- num_req, 4, number of requesters (2..8).
- adress_width, 4, FIFO address width; the bank has 2**adress_width FIFOs.
- data_width, 8, data bus width.
- len_width, 4, burst length field width; a field value L means L+1 beats.
- timeout, 16, consecutive not-ready cycles before a burst aborts (≥2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  num_req  request level per requester, sampled only in IDLE.
- req_push  in  num_req  1 = push burst, 0 = pop burst.
- req_adress  in  num_req*adress_width  target FIFO address, packed; requester i occupies slice i.
- req_len  in  num_req*len_width  burst length minus one, packed.
- req_data  in  num_req*data_width  push data, packed; must be valid while granted.
- grant  out  num_req  one-hot; high for the whole burst.
- beat_ack  out  num_req  one-cycle pulse per accepted beat; the requester advances its data on this.
- req_error  out  num_req  one-cycle pulse when the granted burst is aborted by the watchdog.
- resp_valid  out  1  pop data valid.
- resp_data  out  data_width  pop data.
- busy  out  1  high in XFER.
- bus_adress  out  adress_width  drives active_adress of the FIFO bank.
- bus_data_in  out  data_width  drives FIFO data_in.
- bus_read_enable  out  1  FIFO load strobe (push).
- bus_write_enable  out  1  FIFO unload strobe (pop).
- bus_data_out  in  data_width  FIFO data_out.
- fifo_full  in  2**adress_width  per-FIFO full flags.
- fifo_empty  in  2**adress_width  per-FIFO empty flags.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high, all outputs are 0, state = IDLE, and the round-robin pointer is set so requester 0 has top priority.
- States:
  - IDLE: no grant, bus enables 0. If any req is high, pick the first requester at or after pointer+1 (mod num_req). Latch its address, direction and length into registers, then go to XFER next cycle.
  - XFER:
    - grant[g] = 1, bus_adress = latched address.
    - Target ready = !fifo_full[adr] for a push, !fifo_empty[adr] for a pop, evaluated combinationally in the current cycle.
    - If ready: assert bus_read_enable with bus_data_in = req_data slice g (push), or bus_write_enable (pop). beat_ack[g] = 1 the same cycle. Beat counter decrements.
    - Not ready: enables and beat_ack stay 0; the stall counter increments. The stall counter clears on any accepted beat.
  - Exit: after the beat where the counter reaches 0 (last beat), go to IDLE and set pointer = g.
  - Abort: when the stall counter reaches timeout, pulse req_error[g], go to IDLE and set pointer = g. Beats already accepted are not rolled back.
- IDLE always lasts ≥1 cycle between bursts (bus turnaround); enables are never high in IDLE.
- resp_valid: registered; high exactly the cycle after a pop beat.
- resp_data: registered capture of bus_data_out taken on the cycle after the pop strobe; stable while resp_valid is high.
- After grant, req, req_push, req_adress and req_len are ignored until the burst ends. Dropping req mid-burst does not shorten it.
- bus_read_enable and bus_write_enable are never high together. Outside XFER, bus_data_in = 0.
- Fairness: a requester that holds req continuously is granted within num_req bursts.
- Reset mid-burst: outputs are immediately 0. The partial burst is lost and is not reported on req_error.
- A req_len value of 2**len_width−1 gives the maximum burst of 2**len_width beats. The counter must not wrap.

Test Plan:
- Reset, then req[0]=1, push, adr=7, len=3, data 1..4 advanced on beat_ack, FIFO depth 4 empty → IDLE 1 cycle, grant[0] 4 cycles, 4 bus_read_enable pulses with data 1,2,3,4, back to IDLE, fifo_full[7]=1.
- req[1] pop adr=7, len=3 after the push above → 4 bus_write_enable pulses; resp_valid on the following cycles with resp_data 1,2,3,4.
- req[0..3] all held high, len=0 each → grants in order 0,1,2,3,0 with one IDLE cycle between grants; bursts within 5 grants.
- Push len=5 into a depth-4 FIFO that is never popped → 4 beats accepted, then 16 stall cycles, req_error[g] pulse, return to IDLE, pointer advanced.
- Pop burst with fifo_empty toggling 1,0,1,0 → beat_ack only in cycles where empty=0; burst completes without error.
- Assert reset in the 2nd beat of a 4-beat push → all outputs 0 that cycle; after release, requester 0 has priority and req_error stays 0.
